layer_mixer: RTL

// Parametrised pixel compositor for the Pong video path; next generation of the fixed two-paddle/ball renderer.

---
 rtl/layer_mixer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/layer_mixer.sv
// Pong pixel compositor: priority layer select + grid/background (stage 1),
// game-state screens with blink and play-entry fade (stage 2, output register).
module layer_mixer #(
    parameter int NUM_LAYERS  = 4,
    parameter int RGB_W       = 12,
    parameter int GRID_X      = 100,
    parameter int GRID_Y      = 100,
    parameter int BLINK_TICKS = 500,
    parameter int FADE_TICKS  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        video_on,
    input  logic                        clk_1ms,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [RGB_W-1:0]            grid_rgb,
    input  logic [1:0]                  game_state,
    output logic [RGB_W-1:0]            rgb
);
    localparam int CH = RGB_W / 3;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int FW = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;

    typedef enum logic {FADE, STEADY} fade_state_t;

    logic [RGB_W-1:0] sel_rgb_q, sel_rgb_d, l0_rgb_q, l1_rgb_q, rgb_q, rgb_d;
    logic             vid_q, grid_q, grid_d;
    logic [1:0]       gs_q;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [FW-1:0]    fade_cnt_q, fade_cnt_d;
    logic [1:0]       fade_sh_q, fade_sh_d;
    fade_state_t      state_q, state_d;
    logic             gs_chg;

    // Stage 1: lowest-index hit wins, so scan downwards and let later hits override.
    always_comb begin
        grid_d    = (x == 10'(GRID_X)) || (y == 10'(GRID_Y));
        sel_rgb_d = grid_d ? grid_rgb : bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) sel_rgb_d = layer_rgb[i*RGB_W +: RGB_W];
        end
    end

    assign gs_chg = (game_state != gs_q);

    // A state change restarts the blink phase and swallows any coincident strobe.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (gs_chg) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (clk_1ms) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fade_sh_d  = fade_sh_q;
        fade_cnt_d = fade_cnt_q;
        if (gs_chg) begin
            fade_cnt_d = '0;
            if (game_state == 2'b01) begin
                fade_sh_d = 2'd3;
                state_d   = FADE;
            end else begin
                fade_sh_d = 2'd0;
                state_d   = STEADY;
            end
        end else begin
            case (state_q)
                FADE: begin
                    if (clk_1ms) begin
                        if (fade_cnt_q == FW'(FADE_TICKS - 1)) begin
                            fade_cnt_d = '0;
                            fade_sh_d  = fade_sh_q - 2'd1;
                            if (fade_sh_q == 2'd1) state_d = STEADY;
                        end else begin
                            fade_cnt_d = fade_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 2: screen selection by the game state aligned with this pixel.
    always_comb begin
        rgb_d = '0;
        if (vid_q) begin
            case (gs_q)
                2'b01: for (int c = 0; c < 3; c++)
                           rgb_d[c*CH +: CH] = sel_rgb_q[c*CH +: CH] >> fade_sh_q;
                2'b00: if (grid_q && blink_on_q) rgb_d = grid_rgb;
                2'b10: rgb_d = blink_on_q ? l0_rgb_q : bg_rgb;
                default: rgb_d = blink_on_q ? l1_rgb_q : bg_rgb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_rgb_q   <= '0;
            l0_rgb_q    <= '0;
            l1_rgb_q    <= '0;
            vid_q       <= 1'b0;
            grid_q      <= 1'b0;
            gs_q        <= 2'b00;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            fade_cnt_q  <= '0;
            fade_sh_q   <= 2'd0;
            state_q     <= STEADY;
            rgb_q       <= '0;
        end else begin
            sel_rgb_q   <= sel_rgb_d;
            l0_rgb_q    <= layer_rgb[0 +: RGB_W];
            l1_rgb_q    <= layer_rgb[RGB_W +: RGB_W];
            vid_q       <= video_on;
            grid_q      <= grid_d;
            gs_q        <= game_state;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            fade_cnt_q  <= fade_cnt_d;
            fade_sh_q   <= fade_sh_d;
            state_q     <= state_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb = rgb_q;
endmodule
